regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Writeback-side driver for the 32x32 register file. It is the writer end of the register file's write port (Awr/Din/WrEn).
- Buffers up to DEPTH pending writebacks (dest, data) from the pipeline and drains one per clock into the register file's single write port.
- Provides same-cycle bypass data for the two register-file read addresses, so readers never see stale values while writes are still queued.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- Clk  in  1  rising-edge clock, shared with the register file.
- Rst  in  1  synchronous, active-high reset.
- In_Valid  in  1  writeback request valid.
- In_Ready  out  1  queue can accept a request this cycle.
- In_Addr  in  5  destination register.
- In_Data  in  32  writeback data.
- Hold  in  1  stall drain (the register file write port is busy or frozen).
- Awr  out  5  register file write address.
- Din  out  32  register file write data.
- WrEn  out  1  register file write enable.
- Adr1  in  5  read address 1, as driven to the register file.
- Adr2  in  5  read address 2, as driven to the register file.
- Hit1  out  1  Adr1 matches a queued entry.
- Hit2  out  1  Adr2 matches a queued entry.
- Fwd1  out  32  bypass data for Adr1.
- Fwd2  out  32  bypass data for Adr2.
- Count  out  PTR_W+1  occupancy.
- Empty  out  1  Count==0.
- Full  out  1  Count==DEPTH.

Behaviour:
- Storage: circular buffer with DEPTH entries {addr[4:0], data[31:0]}, head pointer, tail pointer, and an occupancy counter. Pointers wrap modulo DEPTH.
- Reset (Rst high at a Clk edge): head=tail=0, Count=0. Consequently WrEn=0, Empty=1, Full=0, In_Ready=1, Hit1=Hit2=0, Fwd1=Fwd2=0. Entry contents are don't-care. Reset wins over any simultaneous push or pop; a mid-drain reset discards all pending entries.
- In_Ready = !Full (combinational). No push while full, even when a pop occurs in the same cycle.
- Push = In_Valid & In_Ready & (In_Addr != 0). On push, the entry is written at tail and tail advances. A request with In_Addr==0 is accepted (handshake completes) but discarded; Count is unchanged.
- Drain is combinational from head:
  - WrEn = !Empty & !Hold.
  - Awr = head addr, Din = head data.
  - When Empty, Awr=0 and Din=0.
  - Pop = WrEn. At the same edge the register file samples the write, head advances.
- Count next = Count + push − pop. Simultaneous push and pop leaves Count unchanged.
- Latency: a request pushed into an empty queue with Hold=0 appears on WrEn/Awr/Din in the cycle after acceptance and is written at the end of that cycle.
- Hold high: WrEn=0 and the queue keeps filling until Full. Hold has no effect on bypass.
- Bypass (combinational, per read port):
  - Search all valid entries for addr==AdrN.
  - On a match, HitN=1 and FwdN = data of the youngest matching entry (closest to tail).
  - No match, or AdrN==0: HitN=0, FwdN=0.
  - The head entry popping this cycle still counts as a hit. The register file read after the edge returns the written value, so there is no gap.
  - A request being pushed this cycle is not forwarded until the next cycle.
- Ordering: writes to the same address drain in acceptance order, so the last accepted value wins in the register file.

Decomposition:
- Shared package: REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=5'd0, and the entry struct {addr, data}.
- Sub-module regfile_wb_match: combinational youngest-first match over the entry array for one read address. It is instantiated twice, once for Adr1 and once for Adr2.
- The queue, pointers, and counter stay in the top module.

Test Plan:
- Reset then idle → WrEn=0, Empty=1, In_Ready=1, Hit1=Hit2=0, Fwd1=Fwd2=0.
- Push (1, 0x00000001) with Hold=0 → next cycle WrEn=1, Awr=1, Din=0x1; following cycle Empty=1. A read of register 1 from the register file returns 0x1.
- Hold=1, push (2, 0xA), (3, 0xB), (2, 0xC), (4, 0xD):
  - Full=1, In_Ready=0, WrEn=0.
  - Adr1=2 → Hit1=1, Fwd1=0xC. Adr2=5 → Hit2=0.
  - Drop Hold → writes drain in order 2, 3, 2, 4 over 4 cycles with Din 0xA, 0xB, 0xC, 0xD.
- Push (0, 0xFFFFFFFF) → handshake completes, Count stays 0, WrEn never asserts. Adr1=0 → Hit1=0.
- Keep the queue at Count=2 with Hold=0 and push every cycle for 10 cycles, addresses 1..10 → Count constant at 2, pointers wrap, drained Awr sequence is strictly in push order.
- Assert Rst while Count=3 and Hold=1 → next cycle Count=0, WrEn=0, Hit1=0, and no stale entry ever drains afterwards.

Source files
------------

// File: rtl/regfile_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_queue_pkg
//  Description : Shared widths, the zero-register constant and the queue
//                entry layout for the register-file writeback queue.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_wb_queue_pkg;

    localparam int              REG_ADDR_W = 5;
    localparam int              REG_DATA_W = 32;
    localparam logic [4:0]      ZERO_REG   = 5'd0;

    // One pending writeback: destination register and the value to write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : regfile_wb_queue_pkg
`default_nettype wire

// File: rtl/regfile_wb_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_queue_if
//  Description : Bundle of the writeback request handshake, the register-file
//                write port, the two bypass read ports and queue status.
//                master : pipeline / register-file side (drives requests,
//                         Hold and read addresses)
//                slave  : writeback queue
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_wb_queue_if #(
    parameter int PTR_W = 2
);
    import regfile_wb_queue_pkg::*;

    logic                   In_Valid;
    logic                   In_Ready;
    logic [REG_ADDR_W-1:0]  In_Addr;
    logic [REG_DATA_W-1:0]  In_Data;
    logic                   Hold;
    logic [REG_ADDR_W-1:0]  Awr;
    logic [REG_DATA_W-1:0]  Din;
    logic                   WrEn;
    logic [REG_ADDR_W-1:0]  Adr1;
    logic [REG_ADDR_W-1:0]  Adr2;
    logic                   Hit1;
    logic                   Hit2;
    logic [REG_DATA_W-1:0]  Fwd1;
    logic [REG_DATA_W-1:0]  Fwd2;
    logic [PTR_W:0]         Count;
    logic                   Empty;
    logic                   Full;

    modport master (
        output In_Valid, In_Addr, In_Data, Hold, Adr1, Adr2,
        input  In_Ready, Awr, Din, WrEn, Hit1, Hit2, Fwd1, Fwd2,
               Count, Empty, Full
    );

    modport slave (
        input  In_Valid, In_Addr, In_Data, Hold, Adr1, Adr2,
        output In_Ready, Awr, Din, WrEn, Hit1, Hit2, Fwd1, Fwd2,
               Count, Empty, Full
    );

endinterface : regfile_wb_queue_if
`default_nettype wire

// File: rtl/regfile_wb_match.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_match
//  Description : Combinational bypass lookup for one read address. Scans the
//                live entries oldest to youngest so the youngest match wins.
//  Ports       : i_entries  entry storage (indexed by physical slot)
//                i_head     slot of the oldest live entry
//                i_count    number of live entries
//                i_adr      read address to look up
//                o_hit      a live entry targets i_adr (never for register 0)
//                o_fwd      data of the youngest matching entry, else 0
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_match
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wire wb_entry_t [DEPTH-1:0]  i_entries,
    input  wire logic [PTR_W-1:0]       i_head,
    input  wire logic [PTR_W:0]         i_count,
    input  wire logic [REG_ADDR_W-1:0]  i_adr,
    output logic                        o_hit,
    output logic [REG_DATA_W-1:0]       o_fwd
);

    logic [PTR_W-1:0] w_idx;

    // Later (younger) matches overwrite earlier ones, giving last-writer data.
    always_comb begin
        o_hit = 1'b0;
        o_fwd = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PTR_W'(i);
            if ((i_adr != ZERO_REG) && ((PTR_W+1)'(i) < i_count) &&
                (i_entries[w_idx].addr == i_adr)) begin
                o_hit = 1'b1;
                o_fwd = i_entries[w_idx].data;
            end
        end
    end

endmodule : regfile_wb_match
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_queue
//  Description : Writeback queue in front of the 32x32 register file write
//                port. Buffers up to DEPTH (dest, data) writebacks, drains one
//                per clock into Awr/Din/WrEn, and supplies bypass data for
//                both register-file read addresses.
//  Ports       : Clk  rising-edge clock shared with the register file
//                Rst  synchronous active-high reset
//                bus  request handshake, write port, bypass ports, status
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wire logic           Clk,
    input  wire logic           Rst,
    regfile_wb_queue_if.slave   bus
);

    wb_entry_t [DEPTH-1:0]  r_mem;
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [PTR_W:0]         r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // Register-0 writes complete the handshake but are never stored.
    assign w_push  = bus.In_Valid & ~w_full & (bus.In_Addr != ZERO_REG);
    // The register file samples Awr/Din at the same edge the head advances.
    assign w_pop   = ~w_empty & ~bus.Hold;

    assign bus.In_Ready = ~w_full;
    assign bus.WrEn     = w_pop;
    assign bus.Awr      = w_empty ? ZERO_REG : r_mem[r_head].addr;
    assign bus.Din      = w_empty ? '0       : r_mem[r_head].data;
    assign bus.Count    = r_count;
    assign bus.Empty    = w_empty;
    assign bus.Full     = w_full;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

    // Entry payload needs no reset; only slots below Count are ever observed.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_tail].addr <= bus.In_Addr;
            r_mem[r_tail].data <= bus.In_Data;
        end
    end

    regfile_wb_match #(
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_match1 (
        .i_entries  (r_mem),
        .i_head     (r_head),
        .i_count    (r_count),
        .i_adr      (bus.Adr1),
        .o_hit      (bus.Hit1),
        .o_fwd      (bus.Fwd1)
    );

    regfile_wb_match #(
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_match2 (
        .i_entries  (r_mem),
        .i_head     (r_head),
        .i_count    (r_count),
        .i_adr      (bus.Adr2),
        .o_hit      (bus.Hit2),
        .o_fwd      (bus.Fwd2)
    );

endmodule : regfile_wb_queue
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_queue
//  Description : Self-checking bench for regfile_wb_queue. A FIFO-of-records
//                reference model predicts every output each cycle; a register
//                file image built from the DUT's writes is compared against
//                the model's register file at the end.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic Clk;
    logic Rst;

    regfile_wb_queue_if #(.PTR_W(PTR_W)) bus ();

    regfile_wb_queue #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .bus    (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_errors = 0;
    ent_t        q[$];
    logic [31:0] rf_ref [32];
    logic        rf_ref_wr [32];
    logic [31:0] rf_dut [32];

    // Register file image as written by the DUT's write port.
    always @(posedge Clk) begin
        if (bus.WrEn) rf_dut[bus.Awr] <= bus.Din;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check all outputs against the model, then
    // advance the model by the edge.
    task automatic step(input logic rst, input logic v, input logic [4:0] a,
                        input logic [31:0] d, input logic h,
                        input logic [4:0] r1, input logic [4:0] r2);
        logic        e_full, e_empty, e_wren, e_push;
        logic        e_hit1, e_hit2;
        logic [31:0] e_fwd1, e_fwd2, e_din;
        logic [4:0]  e_awr;
        Rst          = rst;
        bus.In_Valid = v;
        bus.In_Addr  = a;
        bus.In_Data  = d;
        bus.Hold     = h;
        bus.Adr1     = r1;
        bus.Adr2     = r2;
        #2;
        e_full  = (q.size() == DEPTH);
        e_empty = (q.size() == 0);
        e_wren  = !e_empty && !h;
        e_awr   = e_empty ? 5'd0  : q[0].a;
        e_din   = e_empty ? 32'd0 : q[0].d;
        e_hit1 = 1'b0; e_fwd1 = 32'd0;
        e_hit2 = 1'b0; e_fwd2 = 32'd0;
        foreach (q[k]) begin
            if (r1 != 5'd0 && q[k].a == r1) begin e_hit1 = 1'b1; e_fwd1 = q[k].d; end
            if (r2 != 5'd0 && q[k].a == r2) begin e_hit2 = 1'b1; e_fwd2 = q[k].d; end
        end
        chk("in_ready", 32'(bus.In_Ready), 32'(!e_full));
        chk("wren",     32'(bus.WrEn),     32'(e_wren));
        chk("awr",      32'(bus.Awr),      32'(e_awr));
        chk("din",      bus.Din,           e_din);
        chk("count",    32'(bus.Count),    32'(q.size()));
        chk("empty",    32'(bus.Empty),    32'(e_empty));
        chk("full",     32'(bus.Full),     32'(e_full));
        chk("hit1",     32'(bus.Hit1),     32'(e_hit1));
        chk("fwd1",     bus.Fwd1,          e_fwd1);
        chk("hit2",     32'(bus.Hit2),     32'(e_hit2));
        chk("fwd2",     bus.Fwd2,          e_fwd2);
        e_push = v && !e_full && (a != 5'd0);
        @(posedge Clk);
        // The register file takes the head write even at a resetting edge.
        if (e_wren) begin
            rf_ref[q[0].a]    = q[0].d;
            rf_ref_wr[q[0].a] = 1'b1;
            void'(q.pop_front());
        end
        if (rst) q.delete();
        else if (e_push) q.push_back('{a: a, d: d});
        #1;
    endtask

    task automatic idle(input logic h, input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, 1'b0, 5'd0, 32'd0, h, r1, r2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_ref[i]    = 32'd0;
            rf_ref_wr[i] = 1'b0;
        end
        Rst = 1'b1;
        bus.In_Valid = 1'b0; bus.In_Addr = 5'd0; bus.In_Data = 32'd0;
        bus.Hold = 1'b0; bus.Adr1 = 5'd0; bus.Adr2 = 5'd0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;

        // Reset state
        idle(1'b0, 5'd1, 5'd2);

        // Single write with no hold
        step(1'b0, 1'b1, 5'd1, 32'h1, 1'b0, 5'd1, 5'd0);
        idle(1'b0, 5'd1, 5'd0);
        idle(1'b0, 5'd1, 5'd0);
        chk("rf_reg1", rf_dut[1], 32'h1);

        // Fill under hold, bypass youngest, then ordered drain
        step(1'b0, 1'b1, 5'd2, 32'hA, 1'b1, 5'd2, 5'd5);
        step(1'b0, 1'b1, 5'd3, 32'hB, 1'b1, 5'd2, 5'd5);
        step(1'b0, 1'b1, 5'd2, 32'hC, 1'b1, 5'd2, 5'd5);
        step(1'b0, 1'b1, 5'd4, 32'hD, 1'b1, 5'd2, 5'd5);
        step(1'b0, 1'b1, 5'd6, 32'hE, 1'b1, 5'd2, 5'd5);
        chk("full_hold", 32'(bus.Full), 32'd1);
        chk("fwd1_hold", bus.Fwd1, 32'hC);
        for (int i = 0; i < 5; i++) idle(1'b0, 5'd2, 5'd4);
        chk("rf_reg2", rf_dut[2], 32'hC);
        chk("rf_reg4", rf_dut[4], 32'hD);

        // Register-0 request is swallowed
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0);
        idle(1'b0, 5'd0, 5'd0);
        idle(1'b0, 5'd0, 5'd0);

        // Steady state at Count=2 with push and pop every cycle
        step(1'b0, 1'b1, 5'd20, 32'h14, 1'b1, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd21, 32'h15, 1'b1, 5'd0, 5'd0);
        for (int k = 1; k <= 10; k++)
            step(1'b0, 1'b1, 5'(k), 32'h100 + 32'(k), 1'b0, 5'(k), 5'(k - 1));
        chk("count_steady", 32'(bus.Count), 32'd2);
        for (int i = 0; i < 3; i++) idle(1'b0, 5'd9, 5'd10);

        // Reset discards pending entries
        step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd0);
        step(1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd7, 5'd0);
        step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 5'd0);
        step(1'b1, 1'b1, 5'd11, 32'hBB, 1'b1, 5'd7, 5'd9);
        chk("count_after_rst", 32'(bus.Count), 32'd0);
        for (int i = 0; i < 4; i++) idle(1'b0, 5'd7, 5'd8);

        // Randomized traffic over a narrow address range to force collisions
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 32'($urandom),
                 ($urandom_range(0, 9) < 3),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0, 5'd0, 5'd0);

        for (int r = 1; r < 32; r++) begin
            if (rf_ref_wr[r]) chk($sformatf("rf_final_%0d", r), rf_dut[r], rf_ref[r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_regfile_wb_queue
`default_nettype wire
